picorv32_wait_mem: RTL
======================

Name: picorv32_wait_mem

Overview:
Parametrised single-port RAM slave for the picorv32 native memory interface. It replaces the fixed always-ready scratch RAM with a proper valid/ready responder. The responder has configurable depth, a configurable number of wait states, byte-strobed writes, out-of-range detection and saturating access counters. It sits directly on the core's mem_* bus inside the SQED top wrapper, so formal and simulation runs can exercise memory stalls.

Parameters:
WORDS, 32, number of 32-bit words; power of two, 2..4096; ABITS = log2(WORDS)
WAIT_STATES, 0, extra cycles between request capture and mem_ready; 0..15
CNT_WIDTH, 16, width of the access counters; 1..32

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
mem_valid  in  1  request valid from core
mem_instr  in  1  request is an instruction fetch; counted only
mem_addr  in  32  byte address; word index = mem_addr[ABITS+1:2]
mem_wdata  in  32  write data
mem_wstrb  in  4  byte write enables; 0 = read
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid only while mem_ready=1
oob_err  out  1  sticky flag: an out-of-range access has occurred
rd_count  out  CNT_WIDTH  completed reads (wstrb=0), saturating
wr_count  out  CNT_WIDTH  completed writes (wstrb!=0), saturating
if_count  out  CNT_WIDTH  completed reads with mem_instr=1, saturating

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - mem_ready=0, mem_rdata=0, oob_err=0, all counters=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_valid=1, capture addr, wdata, wstrb and instr at the edge.
  - If WAIT_STATES=0, go to RESP; otherwise go to WAIT with cnt=WAIT_STATES-1.
- WAIT:
  - While cnt!=0, decrement cnt.
  - When cnt=0, go to RESP.
- Array access happens at the edge that enters RESP:
  - Registered read of the addressed word, read-before-write.
  - Byte lane i is written iff wstrb[i]=1.
- RESP:
  - mem_ready=1 and mem_rdata = word read at entry, for exactly one cycle.
  - For writes, mem_rdata returns the pre-write word.
  - Always return to IDLE; counters and oob_err update at this edge.
- Latency: mem_ready rises WAIT_STATES+1 cycles after the capture edge.
  - Minimum request-to-request spacing is WAIT_STATES+2 cycles.
  - mem_valid seen in the IDLE cycle right after RESP starts a new transaction.
- Outside RESP: mem_ready=0 and mem_rdata=0.
- Out-of-range access (any mem_addr[31:ABITS+2] bit set):
  - No array write; mem_rdata=0 in RESP.
  - Handshake still completes with normal latency.
  - oob_err is set at the RESP-exit edge and stays set until reset.
- Low address bits mem_addr[1:0] are ignored.
- mem_valid dropping during WAIT or RESP is a protocol violation. The captured transaction completes regardless, and inputs are not resampled until IDLE.
- Counters:
  - Exactly one of rd_count/wr_count increments per completed transaction, out-of-range ones included.
  - if_count increments alongside rd_count when captured instr=1.
  - All counters saturate at 2^CNT_WIDTH-1 with no wrap.
- Reset asserted in WAIT:
  - The transaction is abandoned and no array write occurs.
  - mem_ready never pulses for it.
- Reset asserted in RESP:
  - mem_ready drops immediately (asynchronous).
  - The array write already committed at RESP entry persists.

Test Plan:
1. WAIT_STATES=0, WORDS=32: write 0xDEADBEEF to 0x10 with wstrb=0xF, then read 0x10 -> ready 1 cycle after each capture; read returns 0xDEADBEEF; wr_count=1, rd_count=1.
2. Byte strobes: word 0x11223344 at 0x4, write 0xAABBCCDD with wstrb=0x5, then read -> 0x11BB33DD; the write response returns 0x11223344.
3. WAIT_STATES=3: read request held -> mem_ready low for 3 cycles after capture, high on the 4th cycle for exactly 1 cycle; back-to-back requests spaced 5 cycles.
4. Out of range: write 0x55 to 0x80 (WORDS=32), then read 0x80 -> ready pulses; read data 0; oob_err=1 and stays 1; RAM words 0..31 unchanged.
5. Reset mid-WAIT: WAIT_STATES=4, write 0x1234 to 0x8, assert reset 2 cycles after capture -> no ready pulse; a later read of 0x8 returns the old value; counters are 0.
6. Saturation: CNT_WIDTH=2, issue 5 instruction-fetch reads -> rd_count=3, if_count=3, wr_count=0.

Source files
------------

// File: rtl/picorv32_wait_mem.sv
// picorv32_wait_mem
//   Single-port RAM slave for the picorv32 native memory interface. A request
//   is captured in IDLE, optionally delayed by WAIT_STATES cycles, and then
//   answered with a one-cycle mem_ready pulse. The array is accessed on the
//   edge that enters RESP (read-before-write, byte strobed). Accesses beyond
//   the array set a sticky oob_err flag and return zero without writing.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   mem_valid/instr/addr/wdata/wstrb   request from the core
//   mem_ready, mem_rdata  one-cycle completion pulse and read data
//   oob_err               sticky out-of-range flag
//   rd_count, wr_count, if_count   saturating completed-access counters
module picorv32_wait_mem #(
  parameter int WORDS       = 32,
  parameter int WAIT_STATES = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic                 mem_instr,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic                 mem_ready,
  output logic [31:0]          mem_rdata,
  output logic                 oob_err,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic [CNT_WIDTH-1:0] wr_count,
  output logic [CNT_WIDTH-1:0] if_count
);

  localparam int ABITS = $clog2(WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ABITS-1:0]     idx_q, idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic                 instr_q, instr_d;
  logic                 oob_q, oob_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 oob_err_q, oob_err_d;
  logic [CNT_WIDTH-1:0] rd_q, rd_d, wr_q, wr_d, if_q, if_d;

  logic [31:0]          mem [WORDS];

  logic                 req_oob;
  logic                 unused_low_bits;

  // Array access port: driven either by the live request (zero wait states)
  // or by the captured request (leaving WAIT).
  logic                 acc_en;
  logic [ABITS-1:0]     acc_idx;
  logic [31:0]          acc_wdata;
  logic [3:0]           acc_wstrb;
  logic                 acc_oob;
  logic [31:0]          acc_old;
  logic [31:0]          acc_new;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign req_oob         = |mem_addr[31:ABITS+2];
  assign unused_low_bits = ^mem_addr[1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    instr_d   = instr_q;
    oob_d     = oob_q;
    oob_err_d = oob_err_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    if_d      = if_q;
    acc_en    = 1'b0;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_wstrb = wstrb_q;
    acc_oob   = oob_q;

    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          idx_d   = mem_addr[ABITS+1:2];
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          instr_d = mem_instr;
          oob_d   = req_oob;
          if (WAIT_STATES == 0) begin
            state_d   = S_RESP;
            acc_en    = 1'b1;
            acc_idx   = mem_addr[ABITS+1:2];
            acc_wdata = mem_wdata;
            acc_wstrb = mem_wstrb;
            acc_oob   = req_oob;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          acc_en  = 1'b1;
        end
      end
      S_RESP: begin
        state_d   = S_IDLE;
        oob_err_d = oob_err_q | oob_q;
        if (wstrb_q == 4'd0) begin
          rd_d = sat_inc(rd_q);
          if (instr_q) if_d = sat_inc(if_q);
        end else begin
          wr_d = sat_inc(wr_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    acc_old = mem[acc_idx];
    for (int i = 0; i < 4; i++) begin
      acc_new[8*i +: 8] = acc_wstrb[i] ? acc_wdata[8*i +: 8] : acc_old[8*i +: 8];
    end

    // Read data is only held for the RESP cycle; everywhere else it is zero.
    rdata_d = (acc_en && !acc_oob) ? acc_old : 32'd0;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rdata_q   <= 32'd0;
      oob_err_q <= 1'b0;
      rd_q      <= '0;
      wr_q      <= '0;
      if_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      oob_err_q <= oob_err_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      if_q      <= if_d;
    end
  end

  // Captured request fields; only consumed after a capture, so no reset
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
    instr_q <= instr_d;
    oob_q   <= oob_d;
  end

  // RAM array; contents survive reset
  always_ff @(posedge clk) begin
    if (acc_en && !acc_oob && (acc_wstrb != 4'd0)) begin
      mem[acc_idx] <= acc_new;
    end
  end

  assign mem_ready = (state_q == S_RESP);
  assign mem_rdata = rdata_q;
  assign oob_err   = oob_err_q;
  assign rd_count  = rd_q;
  assign wr_count  = wr_q;
  assign if_count  = if_q;

endmodule
